// File: rtl/usd_apu_bridge.sv
// usd_apu_bridge: turns APU block requests into SD CMD17/CMD24 command words,
// streams write payload into the write FIFO, collects the R1 result and
// streams read payload back from the read FIFO, with an abort timeout.
module usd_apu_bridge #(
    parameter int unsigned BLOCK_WORDS = 64,
    parameter int unsigned TIMEOUT_CYC = 1 << 20
) (
    input  logic        apuClk,
    input  logic        apuReset,
    // Block request
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    // Write payload
    input  logic        wrDataValid,
    output logic        wrDataReady,
    input  logic [63:0] wrData,
    // Read payload
    output logic        rdDataValid,
    output logic [63:0] rdData,
    // Completion
    output logic        doneValid,
    output logic [31:0] doneStatus,
    output logic        doneErr,
    // Command FIFO
    output logic [71:0] cmdFifoData,
    output logic        cmdFifoWrEn,
    input  logic        cmdFifoFull,
    // Write FIFO
    output logic [71:0] writeFifoData,
    output logic        writeFifoWrEn,
    input  logic        writeFifoFull,
    // Result FIFO (resultPending high means empty)
    input  logic [35:0] resultFifoData,
    output logic        resultFifoRdEn,
    input  logic        resultPending,
    // Read FIFO
    input  logic [71:0] readFifoData,
    output logic        readFifoRdEn,
    input  logic        readFifoEmpty
);

    localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] BEAT_LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] BEAT_ALL  = CW'(BLOCK_WORDS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_WDATA   = 3'd2;
    localparam logic [2:0] ST_WAITRES = 3'd3;
    localparam logic [2:0] ST_RESRD   = 3'd4;
    localparam logic [2:0] ST_RDATA   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic          rd_pend_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]   status_q;
    logic          err_q;

    logic tmo_hit;
    logic res_err;
    logic accept;

    // Upper FIFO bits carry nothing this bridge consumes.
    logic unused_bits;
    assign unused_bits = ^{resultFifoData[35:33], readFifoData[71:64]};

    assign accept  = (state_q == ST_IDLE) && reqValid;
    assign tmo_hit = ((state_q == ST_WAITRES) || (state_q == ST_RDATA)) && (tmo_q == TMO_LAST);
    // R1 error bits live in [31:19]; bit 32 is the controller's own error flag.
    assign res_err = resultFifoData[32] | (|resultFifoData[31:19]);

    // Read data is presented the cycle after each RdEn (non-FWFT FIFO).
    assign rdDataValid = rd_pend_q;
    assign rdData      = rd_pend_q ? readFifoData[63:0] : 64'h0;

    // Next-state decode and per-state FIFO strobes.
    always_comb begin
        state_d        = state_q;
        reqReady       = 1'b0;
        wrDataReady    = 1'b0;
        cmdFifoWrEn    = 1'b0;
        cmdFifoData    = 72'h0;
        writeFifoWrEn  = 1'b0;
        writeFifoData  = 72'h0;
        resultFifoRdEn = 1'b0;
        readFifoRdEn   = 1'b0;
        doneValid      = 1'b0;
        doneStatus     = 32'h0;
        doneErr        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                reqReady = 1'b1;
                if (reqValid) state_d = ST_CMD;
            end
            ST_CMD: begin
                cmdFifoData = {8'h00, (write_q ? 6'd24 : 6'd17), 26'h0, addr_q};
                if (!cmdFifoFull) begin
                    cmdFifoWrEn = 1'b1;
                    state_d     = write_q ? ST_WDATA : ST_WAITRES;
                end
            end
            ST_WDATA: begin
                wrDataReady = ~writeFifoFull;
                if (wrDataValid && !writeFifoFull) begin
                    writeFifoWrEn = 1'b1;
                    writeFifoData = {8'h00, wrData};
                    if (wr_cnt_q == BEAT_LAST) state_d = ST_WAITRES;
                end
            end
            ST_WAITRES: begin
                if (tmo_hit) begin
                    state_d = ST_DONE;
                end else if (!resultPending) begin
                    resultFifoRdEn = 1'b1;
                    state_d        = ST_RESRD;
                end
            end
            ST_RESRD: begin
                state_d = (!write_q && !res_err) ? ST_RDATA : ST_DONE;
            end
            ST_RDATA: begin
                // Once all reads are issued the last beat is on rdData this cycle.
                if (tmo_hit || (rd_cnt_q == BEAT_ALL)) begin
                    state_d = ST_DONE;
                end else if (!readFifoEmpty) begin
                    readFifoRdEn = 1'b1;
                end
            end
            ST_DONE: begin
                doneValid  = 1'b1;
                doneStatus = status_q;
                doneErr    = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge apuClk or posedge apuReset) begin
        if (apuReset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Request latch, beat counters and pending-read flag.
    always_ff @(posedge apuClk or posedge apuReset) begin
        if (apuReset) begin
            write_q   <= 1'b0;
            addr_q    <= 32'h0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= readFifoRdEn;
            if (accept) begin
                write_q  <= reqWrite;
                addr_q   <= reqAddr;
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (writeFifoWrEn) wr_cnt_q <= wr_cnt_q + CW'(1);
                if (readFifoRdEn)  rd_cnt_q <= rd_cnt_q + CW'(1);
            end
        end
    end

    // Timeout counter: restarts on WAITRES entry, runs through WAITRES and RDATA.
    always_ff @(posedge apuClk or posedge apuReset) begin
        if (apuReset) begin
            tmo_q <= '0;
        end else if ((state_d == ST_WAITRES) && (state_q != ST_WAITRES)) begin
            tmo_q <= '0;
        end else if ((state_q == ST_WAITRES) || (state_q == ST_RDATA)) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Completion status: result capture, or all-ones on timeout.
    always_ff @(posedge apuClk or posedge apuReset) begin
        if (apuReset) begin
            status_q <= 32'h0;
            err_q    <= 1'b0;
        end else if (accept) begin
            status_q <= 32'h0;
            err_q    <= 1'b0;
        end else if (tmo_hit) begin
            status_q <= 32'hFFFF_FFFF;
            err_q    <= 1'b1;
        end else if (state_q == ST_RESRD) begin
            status_q <= resultFifoData[31:0];
            err_q    <= res_err;
        end
    end

endmodule

// File: tb/tb_usd_apu_bridge.sv
// Scoreboard bench for usd_apu_bridge: stimulus pushes expected command words,
// write beats, read beats and completions; a negedge monitor pops and compares.
module tb_usd_apu_bridge;

    localparam int unsigned BW  = 64;
    localparam int unsigned TMO = 100;

    logic        apuClk;
    logic        apuReset;
    logic        reqValid, reqReady, reqWrite;
    logic [31:0] reqAddr;
    logic        wrDataValid, wrDataReady;
    logic [63:0] wrData;
    logic        rdDataValid;
    logic [63:0] rdData;
    logic        doneValid, doneErr;
    logic [31:0] doneStatus;
    logic [71:0] cmdFifoData;
    logic        cmdFifoWrEn, cmdFifoFull;
    logic [71:0] writeFifoData;
    logic        writeFifoWrEn, writeFifoFull;
    logic [35:0] resultFifoData = '0;
    logic        resultFifoRdEn, resultPending;
    logic [71:0] readFifoData = '0;
    logic        readFifoRdEn, readFifoEmpty;

    usd_apu_bridge #(.BLOCK_WORDS(BW), .TIMEOUT_CYC(TMO)) dut (
        .apuClk(apuClk), .apuReset(apuReset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqAddr(reqAddr),
        .wrDataValid(wrDataValid), .wrDataReady(wrDataReady), .wrData(wrData),
        .rdDataValid(rdDataValid), .rdData(rdData),
        .doneValid(doneValid), .doneStatus(doneStatus), .doneErr(doneErr),
        .cmdFifoData(cmdFifoData), .cmdFifoWrEn(cmdFifoWrEn), .cmdFifoFull(cmdFifoFull),
        .writeFifoData(writeFifoData), .writeFifoWrEn(writeFifoWrEn),
        .writeFifoFull(writeFifoFull),
        .resultFifoData(resultFifoData), .resultFifoRdEn(resultFifoRdEn),
        .resultPending(resultPending),
        .readFifoData(readFifoData), .readFifoRdEn(readFifoRdEn), .readFifoEmpty(readFifoEmpty)
    );

    initial apuClk = 1'b0;
    always #5 apuClk = ~apuClk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge apuClk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] status;
        logic        err;
        int          lat;   // cycles from command write to doneValid, -1 = unchecked
    } done_t;

    logic [71:0] exp_cmd[$];
    logic [71:0] exp_wr[$];
    logic [63:0] exp_rd[$];
    done_t       exp_done[$];

    // Non-FWFT FIFO models: data appears the cycle after RdEn.
    logic [71:0] rd_words[0:255];
    int rd_pushed = 0, rd_popped = 0;
    assign readFifoEmpty = (rd_pushed == rd_popped);
    always @(posedge apuClk) begin
        if (readFifoRdEn) begin
            readFifoData <= rd_words[rd_popped];
            rd_popped    <= rd_popped + 1;
        end
    end

    logic [35:0] res_words[0:15];
    int res_pushed = 0, res_popped = 0;
    assign resultPending = (res_pushed == res_popped);
    always @(posedge apuClk) begin
        if (resultFifoRdEn) begin
            resultFifoData <= res_words[res_popped];
            res_popped     <= res_popped + 1;
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor counters
    int cmd_cnt = 0, wr_pulses = 0, rd_pulses = 0, rden_cnt = 0, done_cnt = 0;
    int cmd_cyc = 0;

    initial begin
        done_t d;
        forever begin
            @(negedge apuClk);
            if (!apuReset) begin
                if (cmdFifoWrEn) begin
                    cmd_cnt++;
                    cmd_cyc = cyc;
                    chk("cmd_wren_while_full", 72'(cmdFifoFull), 72'd0);
                    if (exp_cmd.size() == 0) chk("cmd_unexpected", 72'd1, 72'd0);
                    else chk("cmd_data", cmdFifoData, exp_cmd.pop_front());
                end
                if (writeFifoWrEn) begin
                    wr_pulses++;
                    chk("wr_wren_while_full", 72'(writeFifoFull), 72'd0);
                    if (exp_wr.size() == 0) chk("wr_unexpected", 72'd1, 72'd0);
                    else chk("wr_data", writeFifoData, exp_wr.pop_front());
                end
                if (resultFifoRdEn) chk("res_rden_while_empty", 72'(resultPending), 72'd0);
                if (readFifoRdEn) begin
                    rden_cnt++;
                    chk("rd_rden_while_empty", 72'(readFifoEmpty), 72'd0);
                end
                if (rdDataValid) begin
                    rd_pulses++;
                    if (exp_rd.size() == 0) chk("rd_unexpected", 72'd1, 72'd0);
                    else chk("rd_data", 72'(rdData), 72'(exp_rd.pop_front()));
                end
                if (doneValid) begin
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        chk("done_unexpected", 72'd1, 72'd0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_status", 72'(doneStatus), 72'(d.status));
                        chk("done_err", 72'(doneErr), 72'(d.err));
                        if (d.lat >= 0) chk("done_latency", 72'(cyc - cmd_cyc), 72'(d.lat));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge apuClk);
        #1;
    endtask

    task automatic push_done(input logic [31:0] status, input logic err, input int lat);
        done_t d;
        d.status = status;
        d.err    = err;
        d.lat    = lat;
        exp_done.push_back(d);
    endtask

    task automatic push_result(input logic [35:0] w);
        res_words[res_pushed] = w;
        res_pushed++;
    endtask

    task automatic load_rd(input int n, input int base);
        logic [71:0] w;
        for (int i = 0; i < n; i++) begin
            w = {8'hA5, 16'hDA7A, 16'(base + i), 32'h5A5A_0000 + 32'(base + i)};
            rd_words[rd_pushed] = w;
            rd_pushed++;
            exp_rd.push_back(w[63:0]);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'h1357_0000 + 32'(i)};
    endfunction

    // Called at posedge+1; request is taken on the next edge.
    task automatic issue(input logic wr, input logic [31:0] addr);
        exp_cmd.push_back({8'h00, (wr ? 6'd24 : 6'd17), 26'h0, addr});
        chk("req_ready", 72'(reqReady), 72'd1);
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        step();
        reqValid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int max_cyc);
        int n = 0;
        while (done_cnt == prev && n < max_cyc) begin
            step();
            n++;
        end
        if (done_cnt == prev) chk("done_wait_expired", 72'd0, 72'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_reqReady"}, 72'(reqReady), 72'd1);
        chk({tag, "_strobes"},
            72'({cmdFifoWrEn, writeFifoWrEn, resultFifoRdEn, readFifoRdEn,
                 rdDataValid, doneValid, wrDataReady, doneErr}), 72'd0);
        chk({tag, "_cmdData"}, cmdFifoData, 72'd0);
        chk({tag, "_wrData"}, writeFifoData, 72'd0);
        chk({tag, "_rdData"}, 72'(rdData), 72'd0);
        chk({tag, "_status"}, 72'(doneStatus), 72'd0);
    endtask

    initial begin
        int d0, c0, r0, idx, k;
        logic acc;
        apuReset = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
        wrDataValid = 1'b0; wrData = '0;
        cmdFifoFull = 1'b0; writeFifoFull = 1'b0;

        #2;
        check_idle_outputs("reset");
        step();
        step();
        apuReset = 1'b0;

        // Read 0x10: CMD C, WAITRES C+1, RESRD C+2, 64 reads C+3..C+66, last beat C+67, DONE C+68
        push_result(36'h0_0000_0900);
        load_rd(64, 0);
        push_done(32'h0000_0900, 1'b0, 68);
        chk("cmd_word_read", {8'h00, 6'd17, 26'h0, 32'h10}, 72'h00_4400_0000_0000_0010);
        d0 = done_cnt;
        issue(1'b0, 32'h0000_0010);
        wait_done(d0, 200);
        chk("read_beats", 72'(rd_pulses), 72'd64);
        chk("read_queue_drained", 72'(exp_rd.size()), 72'd0);

        // Write 0x20, 64 beats, writeFifoFull toggling, wrDataValid held past the block
        push_result(36'h0_0000_0A00);
        for (int i = 0; i < 64; i++) exp_wr.push_back({8'h00, pat(i)});
        push_done(32'h0000_0A00, 1'b0, -1);
        d0 = done_cnt;
        issue(1'b1, 32'h0000_0020);
        idx = 0;
        for (k = 0; k < 400 && done_cnt == d0; k++) begin
            writeFifoFull = (k % 4 == 1) || (k % 4 == 2);
            wrData        = pat(idx);
            wrDataValid   = 1'b1;
            #1;
            acc = wrDataReady;
            step();
            if (acc) idx++;
        end
        wrDataValid   = 1'b0;
        writeFifoFull = 1'b0;
        if (done_cnt == d0) chk("write_done_expired", 72'd0, 72'd1);
        chk("write_pulses", 72'(wr_pulses), 72'd64);
        chk("write_queue_drained", 72'(exp_wr.size()), 72'd0);

        // cmdFifoFull held, then a read whose result has bit 32 set
        cmdFifoFull = 1'b1;
        push_result(36'h1_0000_0000);
        push_done(32'h0, 1'b1, 3);
        c0 = cmd_cnt; r0 = rden_cnt; d0 = done_cnt;
        issue(1'b0, 32'h0000_0030);
        repeat (10) step();
        chk("cmd_held_while_full", 72'(cmd_cnt), 72'(c0));
        cmdFifoFull = 1'b0;
        wait_done(d0, 50);
        chk("cmd_single_pulse", 72'(cmd_cnt), 72'(c0 + 1));
        chk("err_no_reads", 72'(rden_cnt), 72'(r0));

        // Reset during RDATA
        push_result(36'h0_0000_0900);
        load_rd(64, 100);
        push_done(32'h0000_0900, 1'b0, 68);
        r0 = rd_pulses;
        issue(1'b0, 32'h0000_0040);
        for (k = 0; k < 200 && rd_pulses < r0 + 10; k++) step();
        chk("reset_reached_rdata", 72'(rd_pulses >= r0 + 10), 72'd1);
        apuReset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        exp_rd.delete();
        exp_done.delete();
        step();
        step();
        apuReset = 1'b0;

        // First edge after release: read with an R1 error bit (19)
        push_result(36'h0_0008_0000);
        push_done(32'h0008_0000, 1'b1, 3);
        r0 = rden_cnt; d0 = done_cnt;
        issue(1'b0, 32'h0000_0050);
        wait_done(d0, 50);
        chk("r1_err_no_reads", 72'(rden_cnt), 72'(r0));

        // Timeout: no result ever arrives; 100 WAITRES cycles then DONE
        push_done(32'hFFFF_FFFF, 1'b1, 101);
        d0 = done_cnt;
        issue(1'b0, 32'h0000_0060);
        wait_done(d0, 300);
        step();
        chk("done_queue_drained", 72'(exp_done.size()), 72'd0);
        chk("cmd_queue_drained", 72'(exp_cmd.size()), 72'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/usd_apu_bridge.md
USD_APU_BRIDGE -- requirements
Module: usd_apu_bridge

Interface
REQ-001 Parameter BLOCK_WORDS, default 64: 72-bit FIFO words per 512-byte block.
REQ-002 Parameter TIMEOUT_CYC, default 2^20: apuClk cycles allowed for a result before abort.
REQ-003 One clock; reset is asynchronous and active-high. The clock is apuClk and the reset is apuReset.
REQ-004 apuClk  in  1  APU clock; all logic is on its rising edge.
REQ-005 apuReset  in  1  async active-high reset.
REQ-006 reqValid/reqReady  in/out  1/1  block request handshake.
REQ-007 reqWrite  in  1  1 = write block (CMD24), 0 = read block (CMD17).
REQ-008 reqAddr  in  32  SD block address.
REQ-009 wrDataValid/wrDataReady  in/out  1/1, wrData  in  64  write payload stream.
REQ-010 rdDataValid  out  1, rdData  out  64  read payload stream; there is no backpressure.
REQ-011 doneValid  out  1, doneStatus  out  32, doneErr  out  1  completion report.
REQ-012 cmdFifoData  out  72, cmdFifoWrEn  out  1, cmdFifoFull  in  1.
REQ-013 writeFifoData  out  72, writeFifoWrEn  out  1, writeFifoFull  in  1.
REQ-014 resultFifoData  in  36, resultFifoRdEn  out  1, resultPending  in  1; resultPending is high when the result FIFO is EMPTY.
REQ-015 readFifoData  in  72, readFifoRdEn  out  1, readFifoEmpty  in  1.

Function
REQ-016 FIFOs are non-FWFT: read data is valid exactly one cycle after the RdEn cycle.
REQ-017 Command word fields:
- [71:64] = 0.
- [63:58] = command index (6'd17 or 6'd24).
- [57:32] = 0.
- [31:0] = reqAddr.
REQ-018 FSM states: IDLE, CMD, WDATA, WAITRES, RESRD, RDATA, DONE.
REQ-019 IDLE: reqReady=1; a cycle with reqValid=1 latches reqWrite and reqAddr and moves to CMD.
REQ-020 CMD: assert cmdFifoWrEn for one cycle when cmdFifoFull=0; otherwise hold. Next state is WDATA for a write, WAITRES for a read.
REQ-021 WDATA: wrDataReady = ~writeFifoFull.
- Each accepted beat drives writeFifoWrEn=1 in the same cycle with writeFifoData={8'h00,wrData}.
- After BLOCK_WORDS beats, move to WAITRES.
REQ-022 WAITRES: when resultPending=0, pulse resultFifoRdEn for one cycle and move to RESRD.
REQ-023 RESRD: capture resultFifoData[31:0] into the status register.
- Error = resultFifoData[32] OR any of bits [31:19] set (R1 error bits).
- Next state: RDATA for a read without error; otherwise DONE.
REQ-024 RDATA: readFifoRdEn = ~readFifoEmpty each cycle until BLOCK_WORDS reads are issued.
- rdDataValid pulses one cycle after each read, with rdData = readFifoData[63:0].
- Move to DONE once the last word has been presented.
REQ-025 DONE: doneValid=1 for exactly one cycle with doneStatus and doneErr, then return to IDLE.
REQ-026 Timeout counter: cleared on entry to WAITRES; counts every cycle spent in WAITRES or RDATA.
- Reaching TIMEOUT_CYC forces DONE with doneErr=1 and doneStatus=32'hFFFF_FFFF.
- Any read in flight completes its data beat before DONE.
REQ-027 Beat counters are log2(BLOCK_WORDS)+1 bits wide; there is no wrap within a block.
REQ-028 reqValid is ignored outside IDLE.
REQ-029 Write beats never exceed BLOCK_WORDS, even if wrDataValid stays high.
REQ-030 At most one outstanding RdEn per FIFO per cycle; RdEn is never asserted while the corresponding empty flag is high.

Reset
REQ-031 apuReset=1 forces IDLE asynchronously, clears all counters and registers, and drives every WrEn/RdEn/valid output to 0 and reqReady to 1.
REQ-032 All data outputs are 0 in reset.
REQ-033 Reset mid-operation abandons the transfer; the block issues no cleanup writes.
REQ-034 The first request is accepted on the first apuClk edge after reset deasserts.

Verification
REQ-035 Read 0x0000_0010; result 36'h0_0000_0900; 64 read words pre-loaded -> cmdFifoData=72'h00_4400_0000_0000_0010; rdData counts to 64 beats; doneErr=0; doneStatus=0x900.
REQ-036 Write 0x0000_0020 with 64 beats while writeFifoFull toggles -> cmdFifoData[63:58]=24; exactly 64 writeFifoWrEn pulses with data order preserved; DONE follows the result.
REQ-037 cmdFifoFull held high 10 cycles -> no cmdFifoWrEn until it drops, then exactly one pulse.
REQ-038 Read whose result word has bit 32 set -> no readFifoRdEn; doneErr=1 one cycle after status capture.
REQ-039 resultPending held high with TIMEOUT_CYC=100 -> doneValid at cycle 100 after WAITRES entry, doneErr=1, doneStatus=0xFFFF_FFFF.
REQ-040 apuReset asserted mid-RDATA -> outputs go to reset values immediately; a new request is accepted after release.
